// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-Execute pipeline register with load-use hazard detection, branch
// flush and saturating stall/flush event counters.
//
// Parameters
//   XLEN   datapath width of operands, immediate and PC values
//   CNT_W  width of each saturating event counter
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   Valid_D                     Decode holds a real instruction
//   RS1_D/RS2_D/RD_D            register indices from Decode
//   Uses_RS1_D/Uses_RS2_D       instruction really reads rs1/rs2
//   RD1_D/RD2_D/Imm_D/PC_D/PCPlus4_D  operands, immediate, PC values
//   RegWrite_D..Jump_D, ALUControl_D  decoded control
//   PCSrc_E                     branch/jump taken, resolved in Execute
//   *_E                         registered Execute copies of the _D inputs
//   Stall_F/Stall_D             hold PC and IF/ID registers (load-use)
//   Flush_D                     clear IF/ID register (taken branch)
//   StallCount/FlushCount       saturating event counters
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_D,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_D,
  input  logic             Uses_RS1_D,
  input  logic             Uses_RS2_D,
  input  logic [XLEN-1:0]  RD1_D,
  input  logic [XLEN-1:0]  RD2_D,
  input  logic [XLEN-1:0]  Imm_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic [XLEN-1:0]  PCPlus4_D,
  input  logic             RegWrite_D,
  input  logic             MemRead_D,
  input  logic             MemWrite_D,
  input  logic             ALUSrc_D,
  input  logic             Branch_D,
  input  logic             Jump_D,
  input  logic [2:0]       ALUControl_D,
  input  logic             PCSrc_E,
  output logic             Valid_E,
  output logic [4:0]       RS1_E,
  output logic [4:0]       RS2_E,
  output logic [4:0]       RD_E,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  Imm_E,
  output logic [XLEN-1:0]  PC_E,
  output logic [XLEN-1:0]  PCPlus4_E,
  output logic             RegWrite_E,
  output logic             MemRead_E,
  output logic             MemWrite_E,
  output logic             ALUSrc_E,
  output logic             Branch_E,
  output logic             Jump_E,
  output logic [2:0]       ALUControl_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic [2:0]      aluctl;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             load_use;
  logic             rs1_hit, rs2_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load-use hazard: a load in Execute whose destination (never x0) is read by
  // the real instruction sitting in Decode.
  always_comb begin
    rs1_hit  = Uses_RS1_D && (RS1_D == ex_q.rd);
    rs2_hit  = Uses_RS2_D && (RS2_D == ex_q.rd);
    load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
               Valid_D && (rs1_hit || rs2_hit);
  end

  // A taken branch squashes Decode anyway, so it overrides the stall.
  assign Stall_F = load_use && !PCSrc_E;
  assign Stall_D = load_use && !PCSrc_E;
  assign Flush_D = PCSrc_E;

  always_comb begin
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PCSrc_E) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (load_use) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      ex_d.valid   = Valid_D;
      ex_d.rs1     = RS1_D;
      ex_d.rs2     = RS2_D;
      ex_d.rd      = RD_D;
      ex_d.rd1     = RD1_D;
      ex_d.rd2     = RD2_D;
      ex_d.imm     = Imm_D;
      ex_d.pc      = PC_D;
      ex_d.pcplus4 = PCPlus4_D;
      // An invalid slot still carries its data, but must never act.
      if (Valid_D) begin
        ex_d.regwrite = RegWrite_D;
        ex_d.memread  = MemRead_D;
        ex_d.memwrite = MemWrite_D;
        ex_d.alusrc   = ALUSrc_D;
        ex_d.branch   = Branch_D;
        ex_d.jump     = Jump_D;
        ex_d.aluctl   = ALUControl_D;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Valid_E      = ex_q.valid;
  assign RS1_E        = ex_q.rs1;
  assign RS2_E        = ex_q.rs2;
  assign RD_E         = ex_q.rd;
  assign RD1_E        = ex_q.rd1;
  assign RD2_E        = ex_q.rd2;
  assign Imm_E        = ex_q.imm;
  assign PC_E         = ex_q.pc;
  assign PCPlus4_E    = ex_q.pcplus4;
  assign RegWrite_E   = ex_q.regwrite;
  assign MemRead_E    = ex_q.memread;
  assign MemWrite_E   = ex_q.memwrite;
  assign ALUSrc_E     = ex_q.alusrc;
  assign Branch_E     = ex_q.branch;
  assign Jump_E       = ex_q.jump;
  assign ALUControl_E = ex_q.aluctl;
  assign StallCount   = stall_cnt_q;
  assign FlushCount   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic Valid_D, Uses_RS1_D, Uses_RS2_D, PCSrc_E;
  logic [4:0] RS1_D, RS2_D, RD_D;
  logic [XLEN-1:0] RD1_D, RD2_D, Imm_D, PC_D, PCPlus4_D;
  logic RegWrite_D, MemRead_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D;
  logic [2:0] ALUControl_D;
  logic Valid_E, RegWrite_E, MemRead_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E;
  logic [4:0] RS1_E, RS2_E, RD_E;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E;
  logic [2:0] ALUControl_E;
  logic Stall_F, Stall_D, Flush_D;
  logic [CNT_W-1:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Valid_D(Valid_D),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
    .Uses_RS1_D(Uses_RS1_D), .Uses_RS2_D(Uses_RS2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_D(Imm_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D), .MemWrite_D(MemWrite_D),
    .ALUSrc_D(ALUSrc_D), .Branch_D(Branch_D), .Jump_D(Jump_D),
    .ALUControl_D(ALUControl_D), .PCSrc_E(PCSrc_E),
    .Valid_E(Valid_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_E(Imm_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .ALUSrc_E(ALUSrc_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
    .ALUControl_E(ALUControl_E), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Flush_D(Flush_D), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Execute-stage contents as seen by the reference model (field order matches dut_e).
  typedef struct packed {
    logic valid; logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pcplus4;
    logic regwrite, memread, memwrite, alusrc, branch, jump;
    logic [2:0] aluctl;
  } exst_t;

  typedef struct {
    exst_t e;
    int    sc;
    int    fc;
  } item_t;

  exst_t dut_e;
  assign dut_e = {Valid_E, RS1_E, RS2_E, RD_E, RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E,
                  RegWrite_E, MemRead_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, ALUControl_E};

  item_t sb[$];
  exst_t m_e;
  int    m_sc, m_fc;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge the DUT presents a new Execute state.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("e_state", dut_e, it.e);
        chk("stall_count", StallCount, it.sc);
        chk("flush_count", FlushCount, it.fc);
      end
    end
  end

  // Called just after a falling edge with Decode inputs already driven.
  task automatic step();
    bit    lu;
    exst_t nxt;
    #1;
    lu = m_e.valid && m_e.memread && (m_e.rd != 0) && Valid_D &&
         ((Uses_RS1_D && RS1_D == m_e.rd) || (Uses_RS2_D && RS2_D == m_e.rd));
    chk("stall_f", Stall_F, lu && !PCSrc_E);
    chk("stall_d", Stall_D, lu && !PCSrc_E);
    chk("flush_d", Flush_D, PCSrc_E);
    nxt = '0;
    if (PCSrc_E) begin
      if (m_fc < CMAX) m_fc++;
    end else if (lu) begin
      if (m_sc < CMAX) m_sc++;
    end else begin
      nxt.valid = Valid_D; nxt.rs1 = RS1_D; nxt.rs2 = RS2_D; nxt.rd = RD_D;
      nxt.rd1 = RD1_D; nxt.rd2 = RD2_D; nxt.imm = Imm_D; nxt.pc = PC_D;
      nxt.pcplus4 = PCPlus4_D;
      if (Valid_D) begin
        nxt.regwrite = RegWrite_D; nxt.memread = MemRead_D; nxt.memwrite = MemWrite_D;
        nxt.alusrc = ALUSrc_D; nxt.branch = Branch_D; nxt.jump = Jump_D;
        nxt.aluctl = ALUControl_D;
      end
    end
    m_e = nxt;
    sb.push_back('{e: nxt, sc: m_sc, fc: m_fc});
    @(negedge clk);
  endtask

  task automatic set_d(input bit v, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit mr, input bit pcs);
    Valid_D = v; RS1_D = 5'(rs1); RS2_D = 5'(rs2); RD_D = 5'(rd);
    Uses_RS1_D = u1; Uses_RS2_D = u2; MemRead_D = mr; PCSrc_E = pcs;
    RD1_D = $urandom; RD2_D = $urandom; Imm_D = $urandom;
    PC_D = $urandom; PCPlus4_D = $urandom;
    RegWrite_D = 1'($urandom); MemWrite_D = 1'($urandom); ALUSrc_D = 1'($urandom);
    Branch_D = 1'($urandom); Jump_D = 1'($urandom); ALUControl_D = 3'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_e_zero"}, dut_e, '0);
    chk({tag, "_stall_cnt"}, StallCount, 0);
    chk({tag, "_flush_cnt"}, FlushCount, 0);
    chk({tag, "_stall_f"}, Stall_F, 0);
    chk({tag, "_stall_d"}, Stall_D, 0);
    m_e = '0; m_sc = 0; m_fc = 0;
  endtask

  initial begin
    rst = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_reset_state("por");
    chk("por_flush_d", Flush_D, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through.
    set_d(1, 1, 2, 5, 1, 1, 0, 0);
    RD1_D = 32'h1234; RegWrite_D = 1'b1;
    step();
    chk("pt_rd_e", RD_E, 5);
    chk("pt_rd1_e", RD1_E, 32'h1234);
    chk("pt_regwrite_e", RegWrite_E, 1);
    chk("pt_stall_f", Stall_F, 0);

    // Load-use: load x7, then dependent on rs2 (held while stalled).
    set_d(1, 0, 0, 7, 0, 0, 1, 0); step();
    set_d(1, 3, 7, 9, 1, 1, 0, 0); step();
    chk("lu_bubble_valid", Valid_E, 0);
    chk("lu_stall_count", StallCount, 1);
    step();
    chk("lu_captured_rd", RD_E, 9);

    // Not a real dependency: rs2 unused, then load to x0.
    set_d(1, 0, 0, 7, 0, 0, 1, 0); step();
    set_d(1, 3, 7, 9, 1, 0, 0, 0); step();
    set_d(1, 0, 0, 0, 0, 0, 1, 0); step();
    set_d(1, 0, 0, 4, 1, 1, 0, 0); step();

    // Branch flush, then flush colliding with a load-use.
    set_d(1, 1, 2, 3, 1, 1, 0, 1); step();
    chk("br_valid_e", Valid_E, 0);
    set_d(1, 0, 0, 6, 0, 0, 1, 0); step();
    set_d(1, 6, 0, 8, 1, 0, 0, 1); step();
    chk("sim_flush_count", FlushCount, 2);
    chk("sim_stall_count", StallCount, 1);

    // Nine load-use stalls: counter must stick at its maximum.
    for (int i = 0; i < 9; i++) begin
      set_d(1, 0, 0, 10 + i, 0, 0, 1, 0); step();
      set_d(1, 10 + i, 0, 1, 1, 0, 0, 0); step();
      step();
    end
    chk("sat_stall_count", StallCount, CMAX);

    // Asynchronous reset between edges while a stall is being requested.
    set_d(1, 0, 0, 12, 0, 0, 1, 0); step();
    set_d(1, 0, 12, 1, 0, 1, 0, 0);
    #2;
    chk("pre_rst_stall_f", Stall_F, 1);
    rst = 1'b1;
    #1;
    check_reset_state("async");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_d(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      step();
    end

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-Execute pipeline register with integrated load-use hazard detection and branch flush.
- Captures decoded operands and control signals into the Execute stage.
- Supplies RS1_E/RS2_E/RD_E to the forwarding unit downstream.
- Raises Stall_F/Stall_D when a load in Execute feeds the instruction in Decode, and inserts a bubble on stall or taken branch.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Valid_D  input  1  Decode holds a real instruction.
- RS1_D, RS2_D, RD_D  input  5 each  register indices from Decode.
- Uses_RS1_D, Uses_RS2_D  input  1 each  instruction actually reads rs1/rs2.
- RD1_D, RD2_D, Imm_D, PC_D, PCPlus4_D  input  XLEN each  operands, immediate, PC values.
- RegWrite_D, MemRead_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D  input  1 each  decoded control.
- ALUControl_D  input  3  ALU operation.
- PCSrc_E  input  1  branch/jump taken, resolved in Execute this cycle.
- Valid_E, RS1_E, RS2_E, RD_E, RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E, RegWrite_E, MemRead_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, ALUControl_E  output  same widths as the _D inputs  registered Execute copies.
- Stall_F, Stall_D  output  1 each  hold the PC register and the IF/ID register.
- Flush_D  output  1  clear the IF/ID register.
- StallCount, FlushCount  output  CNT_W each  saturating event counters.

Behaviour:
- Reset, asynchronous, applied immediately:
  - every _E output is 0, which is a bubble: Valid_E=0, RD_E=0, all control low.
  - StallCount=FlushCount=0.
  - Stall_F, Stall_D and Flush_D are combinational and evaluate to 0 while the _E state is zero and PCSrc_E=0.
- Load-use hazard, combinational: LoadUse = Valid_E & MemRead_E & (RD_E!=0) & Valid_D & ((Uses_RS1_D & RS1_D==RD_E) | (Uses_RS2_D & RS2_D==RD_E)).
- Stall_F = Stall_D = LoadUse & ~PCSrc_E.
- Flush_D = PCSrc_E.
- Per rising clk, in priority order:
  1. PCSrc_E=1: load a bubble (all _E outputs 0); FlushCount += 1.
  2. else LoadUse=1: load a bubble; StallCount += 1. The Decode instruction is held upstream and re-presented next cycle.
  3. else: capture every _D input into its _E output. A Valid_D=0 input still captures, but all control in _E is forced 0.
- Latency: exactly 1 cycle from a _D input to its _E output. No other state.
- Bubble definition: Valid_E=0, RS1_E=RS2_E=RD_E=0, all control 0, data fields 0. The forwarding unit then never matches, because x0 is excluded there.
- Load into x0 (RD_E=0) never stalls.
- A stall lasts exactly one cycle: the bubble clears MemRead_E, so LoadUse drops the next cycle.
- PCSrc_E together with LoadUse: the flush wins, no stall is asserted, and only FlushCount increments.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall or mid-flush: all state clears immediately, and the stall outputs drop in the same cycle.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset, then pass-through: assert rst, check all _E=0 and StallCount=0. Release, drive Valid_D=1, RD_D=5, RD1_D=32'h1234, RegWrite_D=1 -> next cycle RD_E=5, RD1_E=32'h1234, RegWrite_E=1, Stall_F=0.
- Load-use: E holds a load with RD_E=7, MemRead_E=1; D has RS2_D=7, Uses_RS2_D=1 -> Stall_F=Stall_D=1. Next edge: bubble in E, StallCount=1. Following cycle: Stall=0 and the D instruction is captured.
- Not a real dependency: same as above but Uses_RS2_D=0 (or RD_E=0) -> no stall, instruction captured normally.
- Branch flush: PCSrc_E=1 with a valid D instruction -> Flush_D=1 that cycle; next edge Valid_E=0, RegWrite_E=0, FlushCount=1.
- Simultaneous: force PCSrc_E=1 while the LoadUse condition is true -> Stall_F=0, Flush_D=1, bubble loaded, FlushCount increments, StallCount unchanged.
- Saturation and async reset: CNT_W=3, create 9 load-use stalls -> StallCount holds at 7. Then assert rst between clock edges -> StallCount=0 and all _E=0 before the next edge.
